// File: rtl/sequence_frame_feeder.sv
// Frame-aligned FIFO input stage feeding the sequence sorter with whole FRAME_LEN-sample frames.
// Build option SEQ_FEEDER_SIGNED_OFFSET_EN: store signed samples as offset-binary.
module sequence_frame_feeder #(
   parameter int DW        = 8,
   parameter int FRAME_LEN = 4,
   parameter int DEPTH     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DW-1:0]                in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_flush,
   output logic [DW-1:0]                out_data,
   output logic                         out_valid,
   output logic                         out_pad,
   output logic                         out_frame_start,
   output logic [$clog2(FRAME_LEN)-1:0] out_phase,
   output logic [$clog2(DEPTH):0]       level
);

   localparam int PW = $clog2(FRAME_LEN);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          active, flush_pending;
   logic          push, pop, decide, issue_full, issue_pad, slot, flush_done;
   logic [DW-1:0] push_data;

   always_comb begin
`ifdef SEQ_FEEDER_SIGNED_OFFSET_EN
      push_data = {~in_data[DW-1], in_data[DW-2:0]};
`else
      push_data = in_data;
`endif
      in_ready   = (level < (AW+1)'(DEPTH));
      push       = in_valid && in_ready;
      decide     = (out_phase == PW'(FRAME_LEN-1));
      issue_full = (level >= (AW+1)'(FRAME_LEN));
      issue_pad  = flush_pending && (level != '0);
      // At the decision edge the slot is slot 0 of the new frame; otherwise it continues the current one.
      slot       = decide ? (issue_full || issue_pad) : active;
      pop        = slot && (level != '0);
      flush_done = decide && (issue_full ? (level <= (AW+1)'(FRAME_LEN)) : issue_pad);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         active          <= 1'b0;
         flush_pending   <= 1'b0;
         out_phase       <= '0;
         out_data        <= '0;
         out_valid       <= 1'b0;
         out_pad         <= 1'b0;
         out_frame_start <= 1'b0;
      end else begin
         out_phase <= out_phase + PW'(1);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
         if (decide) active <= issue_full || issue_pad;
         // A clear at the decision edge takes priority over a simultaneous new flush request.
         if (flush_done)
            flush_pending <= 1'b0;
         else if (in_flush && ((level != '0) || push))
            flush_pending <= 1'b1;
         out_valid       <= slot;
         out_pad         <= slot && !pop;
         out_frame_start <= decide && slot;
         out_data        <= pop ? mem[rd_ptr] : '0;
      end
   end

endmodule
